// File: rtl/board_redraw_scheduler.sv
// Redraw sequencer for the 3x3 board: tracks stale cells, runs full-screen clears,
// and hands one cell job at a time to the drawer. Optional frame gating via VSYNC_GATE_EN.
module board_redraw_scheduler #(
    parameter int NUM_CELLS = 9,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mark_valid,
    input  logic [IDX_W-1:0]     mark_idx,
    input  logic                 redraw_all,
`ifdef VSYNC_GATE_EN
    input  logic                 frame_sync,
`endif
    output logic                 draw_start,
    output logic [IDX_W-1:0]     draw_cell_idx,
    output logic [1:0]           draw_row,
    output logic [1:0]           draw_col,
    input  logic                 draw_done,
    output logic                 clr_start,
    input  logic                 clr_done,
    output logic [NUM_CELLS-1:0] dirty_mask,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [IDX_W:0]   NUM_EXT = (IDX_W+1)'(NUM_CELLS);
    localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_CELLS);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_CELLS - 1);

    logic [1:0]           state, state_n;
    logic                 clear_pending, pend_n;
    logic [IDX_W-1:0]     rr_ptr, rr_n;
    logic [NUM_CELLS-1:0] dirty_n;
    logic [NUM_CELLS-1:0] rot;
    logic [IDX_W-1:0]     off, sel;
    logic [IDX_W:0]       sum;
    logic                 found, issue, clr_go, go;

`ifdef VSYNC_GATE_EN
    assign go = frame_sync;
`else
    assign go = 1'b1;
`endif

    // Round-robin pick: rotate the mask so rr_ptr lands at bit 0, take the
    // lowest set bit, then rotate the offset back into a cell index.
    always_comb begin
        rot   = NUM_CELLS'({dirty_mask, dirty_mask} >> rr_ptr);
        found = 1'b0;
        off   = '0;
        for (int k = NUM_CELLS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        sel = (sum >= NUM_EXT) ? IDX_W'(sum - NUM_EXT) : IDX_W'(sum);
    end

    always_comb begin
        state_n = state;
        dirty_n = dirty_mask;
        pend_n  = clear_pending;
        rr_n    = rr_ptr;
        issue   = 1'b0;
        clr_go  = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (clear_pending) begin
                        state_n = S_CLEAR;
                        pend_n  = 1'b0;
                        clr_go  = 1'b1;
                    end else if (|dirty_mask) begin
                        state_n = S_ISSUE;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_done) begin
                    dirty_n = '1;
                    state_n = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (found) begin
                    dirty_n[sel] = 1'b0;
                    rr_n         = (sel == LAST) ? '0 : sel + 1'b1;
                    issue        = 1'b1;
                    state_n      = S_WAIT;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                if (draw_done) state_n = S_IDLE;
            end
        endcase
        // New requests are applied last so a mark colliding with the issued
        // cell keeps it dirty, and a redraw_all in the clear-launch cycle sticks.
        if (redraw_all) pend_n = 1'b1;
        if (mark_valid && (mark_idx < NUM_IDX)) dirty_n[mark_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            dirty_mask    <= '0;
            clear_pending <= 1'b1;
            rr_ptr        <= '0;
            draw_start    <= 1'b0;
            clr_start     <= 1'b0;
            draw_cell_idx <= '0;
            draw_row      <= '0;
            draw_col      <= '0;
            busy          <= 1'b1;
        end else begin
            state         <= state_n;
            dirty_mask    <= dirty_n;
            clear_pending <= pend_n;
            rr_ptr        <= rr_n;
            draw_start    <= issue;
            clr_start     <= clr_go;
            if (issue) begin
                draw_cell_idx <= sel;
                draw_row      <= 2'(sel / 3);
                draw_col      <= 2'(sel % 3);
            end
            busy <= (state_n != S_IDLE) || (|dirty_n) || pend_n;
        end
    end

endmodule

// File: tb/tb_board_redraw_scheduler.sv
// Directed bench for board_redraw_scheduler: reset clear, single mark latency,
// round-robin wrap, mark collision, clear priority, invalid/spurious inputs.
module tb_board_redraw_scheduler;

    localparam int NUM_CELLS = 9;
    localparam int IDX_W     = 4;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 mark_valid;
    logic [IDX_W-1:0]     mark_idx;
    logic                 redraw_all;
    logic                 draw_start;
    logic [IDX_W-1:0]     draw_cell_idx;
    logic [1:0]           draw_row;
    logic [1:0]           draw_col;
    logic                 draw_done;
    logic                 clr_start;
    logic                 clr_done;
    logic [NUM_CELLS-1:0] dirty_mask;
    logic                 busy;
`ifdef VSYNC_GATE_EN
    logic                 frame_sync = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;

    board_redraw_scheduler #(.NUM_CELLS(NUM_CELLS), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn),
        .mark_valid(mark_valid), .mark_idx(mark_idx), .redraw_all(redraw_all),
`ifdef VSYNC_GATE_EN
        .frame_sync(frame_sync),
`endif
        .draw_start(draw_start), .draw_cell_idx(draw_cell_idx),
        .draw_row(draw_row), .draw_col(draw_col), .draw_done(draw_done),
        .clr_start(clr_start), .clr_done(clr_done),
        .dirty_mask(dirty_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input int idx);
        mark_valid = 1'b1;
        mark_idx   = IDX_W'(idx);
        tick();
        mark_valid = 1'b0;
    endtask

    task automatic wait_start(input int exp);
        int n = 0;
        while (!draw_start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", {31'b0, draw_start}, 1);
        chk("cell_idx", {28'b0, draw_cell_idx}, exp);
        chk("row", {30'b0, draw_row}, exp / 3);
        chk("col", {30'b0, draw_col}, exp % 3);
    endtask

    task automatic finish_job(input int exp);
        tick();
        chk("start_pulse", {31'b0, draw_start}, 0);
        tick();
        chk("idx_hold", {28'b0, draw_cell_idx}, exp);
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
    endtask

    task automatic draw_cell(input int exp);
        wait_start(exp);
        finish_job(exp);
    endtask

    always @(negedge clk)
        if (resetn && draw_start && clr_start)
            chk("start_excl", {31'b0, draw_start & clr_start}, 0);

    initial begin
        int n;
        logic saw_draw;
        resetn = 1'b0; mark_valid = 1'b0; mark_idx = '0; redraw_all = 1'b0;
        draw_done = 1'b0; clr_done = 1'b0;
        repeat (3) tick();
        chk("rst_dirty", {23'b0, dirty_mask}, 0);
        chk("rst_draw_start", {31'b0, draw_start}, 0);
        chk("rst_clr_start", {31'b0, clr_start}, 0);
        chk("rst_idx", {28'b0, draw_cell_idx}, 0);
        chk("rst_busy", {31'b0, busy}, 1);

        // Post-reset clear and full redraw
        resetn = 1'b1;
        tick();
        chk("rst_clr_pulse", {31'b0, clr_start}, 1);
        tick();
        chk("clr_pulse_end", {31'b0, clr_start}, 0);
        repeat (9) tick();
        chk("clr_wait_busy", {31'b0, busy}, 1);
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        chk("all_dirty", {23'b0, dirty_mask}, 32'h1FF);
        for (int i = 0; i < NUM_CELLS; i++) draw_cell(i);
        tick();
        chk("rst_end_dirty", {23'b0, dirty_mask}, 0);
        chk("rst_end_busy", {31'b0, busy}, 0);

        // Invalid index and spurious done pulses
        mark(9);
        chk("bad_idx_dirty", {23'b0, dirty_mask}, 0);
        tick();
        chk("bad_idx_busy", {31'b0, busy}, 0);
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        clr_done = 1'b1; tick(); clr_done = 1'b0;
        tick();
        chk("spur_busy", {31'b0, busy}, 0);
        chk("spur_draw", {31'b0, draw_start}, 0);
        chk("spur_clr", {31'b0, clr_start}, 0);

        // Single mark latency: draw_start rises two edges after the mark edge
        mark(4);
        chk("lat_n1", {31'b0, draw_start}, 0);
        tick();
        chk("lat_n2", {31'b0, draw_start}, 0);
        tick();
        chk("lat_n3", {31'b0, draw_start}, 1);
        draw_cell(4);
        tick();
        chk("single_busy", {31'b0, busy}, 0);

        // Round-robin wrap: after 7, pointer sits at 8
        mark(7);
        draw_cell(7);
        mark(2);
        mark(8);
        draw_cell(8);
        draw_cell(2);

        // Mark collision during ISSUE of cell 5
        mark(5);
        tick();
        mark(5);
        chk("coll_start", {31'b0, draw_start}, 1);
        chk("coll_dirty", {23'b0, dirty_mask}, 32'h020);
        finish_job(5);
        draw_cell(5);

        // Clear priority: redraw_all while waiting on cell 3, cell 6 dirty
        mark(3);
        wait_start(3);
        mark(6);
        redraw_all = 1'b1; tick(); redraw_all = 1'b0;
        chk("prio_dirty", {23'b0, dirty_mask}, 32'h040);
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        n = 0; saw_draw = 1'b0;
        while (!clr_start && n < 10) begin
            if (draw_start) saw_draw = 1'b1;
            tick();
            n++;
        end
        chk("prio_clr", {31'b0, clr_start}, 1);
        chk("prio_no_draw", {31'b0, saw_draw}, 0);
        repeat (3) tick();
        clr_done = 1'b1; tick(); clr_done = 1'b0;
        chk("prio_all_dirty", {23'b0, dirty_mask}, 32'h1FF);
        for (int i = 0; i < NUM_CELLS; i++) draw_cell((4 + i) % NUM_CELLS);
        tick();
        chk("prio_end_busy", {31'b0, busy}, 0);
        chk("prio_end_dirty", {23'b0, dirty_mask}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
